// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset core: opcodes, functs,
// FSM state and ALU operation enums, plus the legal-instruction check.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
    } alu_op_t;

    // The halt opcode is handled separately and is not "legal" here.
    function automatic logic legal_instr(input logic [5:0] opc, input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        case (opc)
            OP_RTYPE: ok = (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_ADD) ||
                           (funct == FN_SUB) || (funct == FN_AND) || (funct == FN_OR)  ||
                           (funct == FN_SLT);
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32 x XLEN register file: two async read ports, a debug read port and one
// synchronous write port. Register 0 always reads zero and ignores writes.
module mc_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      ra_addr,
    input  logic [4:0]      rb_addr,
    input  logic [4:0]      dbg_addr,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] ra_data,
    output logic [XLEN-1:0] rb_data,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data  = (ra_addr  == 5'd0) ? '0 : regs[ra_addr];
    assign rb_data  = (rb_addr  == 5'd0) ? '0 : regs[rb_addr];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB control FSM with an
// inline ALU, unified memory port, halt/trap stop state and debug read port.
module mc_datapath
    import mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            retire,
    output logic            halted,
    output logic            trap,
    input  logic [4:0]      dbg_sel,
    output logic [XLEN-1:0] dbg_data,
    output logic [XLEN-1:0] dbg_pc,
    output logic [2:0]      dbg_state
);

    // Memory handshake: a transfer is offered while mem_req=1 with mem_addr,
    // mem_we and mem_wdata held stable; it completes in the cycle mem_ready=1
    // (read data is sampled in that same cycle). mem_ready with mem_req=0 is ignored.

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, alu_q, a_q, b_q, mdr_q;
    logic [31:0]     ir_q;
    logic            trap_q;

    logic [5:0]  opc, funct;
    logic [4:0]  rs, rt, rd, shamt;
    assign opc   = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign shamt = ir_q[10:6];
    assign funct = ir_q[5:0];

    logic [XLEN-1:0] imm_sext, imm_zext, pc_next, br_target, jmp_target;
    assign imm_sext   = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
    assign imm_zext   = {{(XLEN-16){1'b0}}, ir_q[15:0]};
    assign pc_next    = pc_q + XLEN'(PC_STEP);
    assign br_target  = pc_q + (imm_sext * XLEN'(PC_STEP));
    assign jmp_target = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};

    logic is_branch, is_mem, is_sw, is_lw;
    assign is_branch = (opc == OP_BEQ) || (opc == OP_BNE);
    assign is_sw     = (opc == OP_SW);
    assign is_lw     = (opc == OP_LW);
    assign is_mem    = is_sw || is_lw;

    logic [XLEN-1:0] rf_a, rf_b;
    logic            rf_we;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd;

    assign rf_we = (state_q == ST_WB);
    assign rf_wa = (opc == OP_RTYPE) ? rd : rt;
    assign rf_wd = is_lw ? mdr_q : alu_q;

    mc_regfile #(.XLEN(XLEN)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .ra_addr  (rs),
        .rb_addr  (rt),
        .dbg_addr (dbg_sel),
        .we       (rf_we),
        .wa       (rf_wa),
        .wd       (rf_wd),
        .ra_data  (rf_a),
        .rb_data  (rf_b),
        .dbg_data (dbg_data)
    );

    // ALU: lw/sw address generation falls through to the default add with sext(imm).
    alu_op_t         alu_op;
    logic [XLEN-1:0] alu_b, alu_res;

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = imm_sext;
        case (opc)
            OP_RTYPE: begin
                alu_b = b_q;
                case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_ANDI: begin
                alu_op = ALU_AND;
                alu_b  = imm_zext;
            end
            OP_ORI: begin
                alu_op = ALU_OR;
                alu_b  = imm_zext;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = a_q + alu_b;
            ALU_SUB: alu_res = a_q - alu_b;
            ALU_AND: alu_res = a_q & alu_b;
            ALU_OR:  alu_res = a_q | alu_b;
            ALU_SLT: alu_res = XLEN'($signed(a_q) < $signed(alu_b));
            ALU_SLL: alu_res = alu_b << shamt;
            ALU_SRL: alu_res = alu_b >> shamt;
            default: alu_res = '0;
        endcase
    end

    logic req_c, we_c, retire_c;

    always_comb begin
        state_d  = state_q;
        req_c    = 1'b0;
        we_c     = 1'b0;
        retire_c = 1'b0;
        mem_addr = pc_q;
        case (state_q)
            ST_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (opc == OP_HALT || !legal_instr(opc, funct)) begin
                    state_d = ST_HALT;
                end else if (opc == OP_J) begin
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_branch) begin
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                end else if (is_mem) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                req_c    = 1'b1;
                we_c     = is_sw;
                mem_addr = alu_q;
                if (mem_ready) begin
                    retire_c = is_sw;
                    state_d  = is_sw ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                retire_c = 1'b1;
                state_d  = ST_FETCH;
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Gate with rst so a pending request is withdrawn the moment reset asserts.
    assign mem_req   = rst & req_c;
    assign mem_we    = rst & we_c;
    assign retire    = rst & retire_c;
    assign mem_wdata = b_q;
    assign halted    = (state_q == ST_HALT);
    assign trap      = trap_q;
    assign dbg_pc    = pc_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready) begin
                        ir_q <= mem_rdata[31:0];
                        pc_q <= pc_next;
                    end
                end
                ST_DECODE: begin
                    a_q   <= rf_a;
                    b_q   <= rf_b;
                    alu_q <= br_target;
                    if (opc == OP_J && legal_instr(opc, funct)) pc_q <= jmp_target;
                    if (opc != OP_HALT && !legal_instr(opc, funct)) trap_q <= 1'b1;
                end
                ST_EXEC: begin
                    if (is_branch) begin
                        if ((a_q == b_q) ^ (opc == OP_BNE)) pc_q <= alu_q;
                    end else begin
                        alu_q <= alu_res;
                    end
                end
                ST_MEM: begin
                    if (mem_ready && is_lw) mdr_q <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: a small program exercising ALU ops, memory
// stalls, branches, jump, halt, trap and reset during a pending store.
module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we, mem_ready, retire, halted, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_data, dbg_pc;
    logic [4:0]  dbg_sel;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_datapath #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .retire    (retire),
        .halted    (halted),
        .trap      (trap),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data),
        .dbg_pc    (dbg_pc),
        .dbg_state (dbg_state)
    );

    // Memory model: words 0x00-0x3F and >=0x100 answer at once, the data
    // window 0x40-0xFF answers after data_delay wait cycles.
    logic [31:0] mem [0:511];
    int          data_delay = 0;
    int          wait_cnt   = 0;
    logic        in_data;

    assign in_data   = (mem_addr >= 32'h40) && (mem_addr < 32'h100);
    assign mem_ready = mem_req && (wait_cnt >= (in_data ? data_delay : 0));
    assign mem_rdata = mem[mem_addr[10:2]];

    always @(posedge clk) begin
        if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        else                       wait_cnt <= 0;
        if (mem_req && mem_we && mem_ready) mem[mem_addr[10:2]] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_retire(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!retire && n < max);
    endtask

    task automatic check_reg(input logic [4:0] idx, input logic [31:0] exp, input string tag);
        dbg_sel = idx;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic wait_halted(input int max);
        int n;
        n = 0;
        while (!halted && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    logic [4:0]  alu_rd  [6] = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd0};
    logic [31:0] alu_exp [6] = '{32'h0000_8001, 32'h0000_FFFB, 32'h0000_0001,
                                 32'h0000_0050, 32'h0000_000F, 32'h0000_0000};

    initial begin
        int n;
        int req_seen;
        rst        = 1'b0;
        dbg_sel    = 5'd0;
        data_delay = 0;
        for (int i = 0; i < 512; i++) mem[i] = 32'hA5A5_0000 + i;
        mem[0]     = 32'h2008_0005;  // addi $8,$0,5
        mem[1]     = 32'h0108_4820;  // add  $9,$8,$8
        mem[2]     = 32'h0008_5022;  // sub  $10,$0,$8
        mem[3]     = 32'hAC08_0040;  // sw   $8,0x40($0)
        mem[4]     = 32'h1108_FFFF;  // beq  $8,$8,-1
        mem[5]     = 32'h8C0B_0040;  // lw   $11,0x40($0)
        mem[6]     = 32'h0800_0100;  // j    0x100
        mem[9'h100] = 32'h340C_8001; // ori  $12,$0,0x8001
        mem[9'h101] = 32'h314D_FFFF; // andi $13,$10,0xFFFF
        mem[9'h102] = 32'h0148_702A; // slt  $14,$10,$8
        mem[9'h103] = 32'h0008_7900; // sll  $15,$8,4
        mem[9'h104] = 32'h000A_8702; // srl  $16,$10,28
        mem[9'h105] = 32'h2100_0007; // addi $0,$8,7
        mem[9'h106] = 32'hFC00_0000; // halt

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we",  {31'd0, mem_we},  32'd0);
        chk("rst_retire",  {31'd0, retire},  32'd0);
        chk("rst_halted",  {31'd0, halted},  32'd0);
        chk("rst_trap",    {31'd0, trap},    32'd0);
        chk("rst_pc",      dbg_pc,           32'h0);
        chk("rst_state",   {29'd0, dbg_state}, 32'd0);

        @(posedge clk);
        #1 rst = 1'b1;

        wait_retire(20, n);
        chk("addi_cycles", n, 4);
        chk("addi_pc", dbg_pc, 32'h4);
        @(posedge clk); #1;
        check_reg(5'd8, 32'd5, "addi_r8");

        wait_retire(20, n);
        chk("add_cycles", n, 4);
        @(posedge clk); #1;
        check_reg(5'd9, 32'd10, "add_r9");

        wait_retire(20, n);
        @(posedge clk); #1;
        check_reg(5'd10, 32'hFFFF_FFFB, "sub_r10");

        data_delay = 3;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sw_addr",  mem_addr,  32'h40);
            chk("sw_wdata", mem_wdata, 32'h5);
            chk("sw_we",    {31'd0, mem_we}, 32'd1);
        end
        chk("sw_retire_cycle7", {31'd0, retire}, 32'd1);
        @(posedge clk); #1;
        chk("sw_mem40", mem[16], 32'h5);

        wait_retire(20, n);
        chk("beq_cycles", n, 3);
        @(posedge clk); #1;
        chk("beq_pc", dbg_pc, 32'h10);
        mem[4] = 32'h1508_FFFF;      // bne $8,$8,-1

        wait_retire(20, n);
        chk("bne_cycles", n, 3);
        @(posedge clk); #1;
        chk("bne_pc", dbg_pc, 32'h14);

        wait_retire(20, n);
        chk("lw_cycles", n, 8);
        @(posedge clk); #1;
        check_reg(5'd11, 32'd5, "lw_r11");

        wait_retire(20, n);
        chk("j_cycles", n, 2);
        @(posedge clk); #1;
        chk("j_pc", dbg_pc, 32'h400);

        for (int i = 0; i < 6; i++) begin
            wait_retire(20, n);
            chk("alu_cycles", n, 4);
            @(posedge clk); #1;
            check_reg(alu_rd[i], alu_exp[i], $sformatf("alu_r%0d", alu_rd[i]));
        end

        wait_halted(20);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_trap",   {31'd0, trap},   32'd0);
        chk("halt_pc",     dbg_pc,          32'h41C);
        req_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_req || retire) req_seen++;
        end
        chk("halt_quiet", req_seen, 0);
        check_reg(5'd9, 32'd10, "halt_dbg_live");

        rst = 1'b0;
        mem[0] = 32'hAC08_0044;      // sw $8,0x44($0)
        data_delay = 10;
        @(posedge clk); #1 rst = 1'b1;
        n = 0;
        while (dbg_state != 3'd3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rmem_req",  {31'd0, mem_req}, 32'd1);
        chk("rmem_addr", mem_addr, 32'h44);
        #1 rst = 1'b0;
        #1;
        chk("rmem_req_drop", {31'd0, mem_req}, 32'd0);
        chk("rmem_we_drop",  {31'd0, mem_we},  32'd0);
        chk("rmem_state",    {29'd0, dbg_state}, 32'd0);
        mem[0] = 32'hF800_0000;      // opcode 0x3E: illegal
        data_delay = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rmem_no_write", mem[17], 32'hA5A5_0011);
        check_reg(5'd8,  32'd0, "rmem_r8");
        check_reg(5'd11, 32'd0, "rmem_r11");
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("refetch_req",  {31'd0, mem_req}, 32'd1);
        chk("refetch_addr", mem_addr, 32'h0);
        wait_halted(20);
        chk("trap_halted", {31'd0, halted}, 32'd1);
        chk("trap_trap",   {31'd0, trap},   32'd1);
        @(negedge clk);
        chk("trap_req",    {31'd0, mem_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
